// File: rtl/route_lookup_arbiter_if.sv
// Header-capture and route-decision bus shared by the route lookup arbiter
// and whatever drives it (parsers on the ingress side, fabric on the egress side).
interface route_lookup_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]    hdr_valid;
    logic [32*NUM_PORTS-1:0] hdr_ip_dest;
    logic [NUM_PORTS-1:0]    hdr_encap;
    logic [NUM_PORTS-1:0]    hdr_ready;

    logic                    route_valid;
    logic                    route_ready;
    logic [PW-1:0]           route_src_port;
    logic [PW-1:0]           route_dst_port;
    logic                    route_hit;
    logic                    route_encap;

    modport master (
        input  hdr_valid,
        input  hdr_ip_dest,
        input  hdr_encap,
        output hdr_ready,
        output route_valid,
        input  route_ready,
        output route_src_port,
        output route_dst_port,
        output route_hit,
        output route_encap
    );

    modport slave (
        output hdr_valid,
        output hdr_ip_dest,
        output hdr_encap,
        input  hdr_ready,
        input  route_valid,
        output route_ready,
        input  route_src_port,
        input  route_dst_port,
        input  route_hit,
        input  route_encap
    );
endinterface

// File: rtl/route_lookup_arbiter.sv
// route_lookup_arbiter: captures per-parser header pulses, picks one pending
// header round-robin, walks the masked route table one entry per cycle
// (lowest index wins) and presents the decision on a valid/ready handshake.
module route_lookup_arbiter #(
    parameter int  NUM_PORTS    = 4,
    parameter int  TABLE_DEPTH  = 8,
    parameter int  DEFAULT_PORT = 0,
    localparam int PW = (NUM_PORTS   > 1) ? $clog2(NUM_PORTS)   : 1,
    localparam int TW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
    input  logic                   axis_clk,
    input  logic                   axis_resetn,
    route_lookup_arbiter_if.master bus,
    input  logic                   cfg_wr,
    input  logic [TW-1:0]          cfg_addr,
    input  logic [31:0]            cfg_ip,
    input  logic [31:0]            cfg_mask,
    input  logic [PW-1:0]          cfg_port,
    input  logic                   cfg_en,
    output logic [15:0]            miss_count,
    output logic                   err_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESULT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]            tabIp_q   [TABLE_DEPTH];
    logic [31:0]            tabMask_q [TABLE_DEPTH];
    logic [PW-1:0]          tabPort_q [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0] tabEn_q;

    logic [31:0]            capIp_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]   capEncap_q;
    logic [NUM_PORTS-1:0]   pending_q;
    logic [NUM_PORTS-1:0]   hdrReady_q;
    logic                   overflow_q;

    logic [PW-1:0]          last_q;
    logic [PW-1:0]          cur_q;
    logic [PW-1:0]          dst_q;
    logic [31:0]            key_q;
    logic [TW-1:0]          idx_q;
    logic                   hit_q;
    logic                   encap_q;
    logic [15:0]            missCount_q;

    logic                   grantValid;
    logic [PW-1:0]          grantPort;
    logic [PW-1:0]          candPort;
    logic                   entryHit;
    logic                   lastEntry;
    logic                   handshake;

    assign handshake = (state_q == RESULT) && bus.route_ready;
    assign entryHit  = tabEn_q[idx_q] &&
                       ((key_q & tabMask_q[idx_q]) == (tabIp_q[idx_q] & tabMask_q[idx_q]));
    assign lastEntry = (idx_q == TW'(TABLE_DEPTH - 1));

    // Round-robin search for the first pending port after the last one served
    always_comb begin
        grantValid = 1'b0;
        grantPort  = '0;
        candPort   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            candPort = PW'((int'(last_q) + k) % NUM_PORTS);
            if (!grantValid && pending_q[candPort]) begin
                grantValid = 1'b1;
                grantPort  = candPort;
            end
        end
    end

    // Next-state decision for the grant / table walk / result handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grantValid) state_d = LOOKUP;
            LOOKUP:  if (entryHit || lastEntry) state_d = RESULT;
            RESULT:  if (bus.route_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; a reset abandons any lookup or result in flight
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Route table storage; writes land at the edge so the current compare sees old contents
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            tabEn_q <= '0;
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                tabIp_q[e]   <= '0;
                tabMask_q[e] <= '0;
                tabPort_q[e] <= '0;
            end
        end else if (cfg_wr) begin
            tabIp_q[cfg_addr]   <= cfg_ip;
            tabMask_q[cfg_addr] <= cfg_mask;
            tabPort_q[cfg_addr] <= cfg_port;
            tabEn_q[cfg_addr]   <= cfg_en;
        end
    end

    // Per-port header capture; a new pulse beats the handshake release of the same port
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pending_q  <= '0;
            hdrReady_q <= '0;
            capEncap_q <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                capIp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.hdr_valid[i]) begin
                    capIp_q[i]    <= bus.hdr_ip_dest[32*i +: 32];
                    capEncap_q[i] <= bus.hdr_encap[i];
                    pending_q[i]  <= 1'b1;
                    hdrReady_q[i] <= 1'b0;
                    if (pending_q[i] && !(handshake && (cur_q == PW'(i)))) begin
                        overflow_q <= 1'b1;
                    end
                end else if (handshake && (cur_q == PW'(i))) begin
                    pending_q[i]  <= 1'b0;
                    hdrReady_q[i] <= 1'b1;
                end
            end
        end
    end

    // Lookup datapath: load key on grant, compare one entry per cycle, record the outcome
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            last_q      <= PW'(NUM_PORTS - 1);
            cur_q       <= '0;
            key_q       <= '0;
            idx_q       <= '0;
            dst_q       <= '0;
            hit_q       <= 1'b0;
            encap_q     <= 1'b0;
            missCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        cur_q   <= grantPort;
                        key_q   <= capIp_q[grantPort];
                        encap_q <= capEncap_q[grantPort];
                        idx_q   <= '0;
                    end
                end
                LOOKUP: begin
                    if (entryHit) begin
                        dst_q <= tabPort_q[idx_q];
                        hit_q <= 1'b1;
                    end else if (lastEntry) begin
                        dst_q <= PW'(DEFAULT_PORT);
                        hit_q <= 1'b0;
                        if (missCount_q != 16'hFFFF) begin
                            missCount_q <= missCount_q + 16'd1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.route_ready) begin
                        last_q <= cur_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.hdr_ready      = hdrReady_q;
    assign bus.route_valid    = (state_q == RESULT);
    assign bus.route_src_port = cur_q;
    assign bus.route_dst_port = dst_q;
    assign bus.route_hit      = hit_q;
    assign bus.route_encap    = encap_q;
    assign miss_count         = missCount_q;
    assign err_overflow       = overflow_q;

endmodule

// File: doc/route_lookup_arbiter.md
Name: route_lookup_arbiter

Overview:
- Sits between NUM_PORTS parse_packet instances and the egress switch fabric.
- Captures each parser's one-cycle header-valid pulse, arbitrates pending headers round-robin, and resolves each header's IP destination against a masked route table (one entry per cycle, lowest index wins).
- Presents a route decision with valid/ready handshake, then raises that parser's ready so it can accept its next packet.

Parameters:
NUM_PORTS, 4, number of ingress parsers; port index width PW = clog2(NUM_PORTS), minimum 1
TABLE_DEPTH, 8, route table entries; index width TW = clog2(TABLE_DEPTH), minimum 1
DEFAULT_PORT, 0, egress port reported on table miss

Ports:
axis_clk  in  1  clock
axis_resetn  in  1  asynchronous active-low reset
hdr_valid  in  NUM_PORTS  per-parser header pulse (parse_packet valid)
hdr_ip_dest  in  32*NUM_PORTS  per-parser ip_dest_addr; port i at [32*i+31:32*i]
hdr_encap  in  NUM_PORTS  per-parser encapsulated flag
hdr_ready  out  NUM_PORTS  per-parser ready (to parse_packet ready)
cfg_wr  in  1  route table write strobe
cfg_addr  in  TW  entry index
cfg_ip  in  32  entry prefix
cfg_mask  in  32  entry mask
cfg_port  in  PW  entry egress port
cfg_en  in  1  entry valid bit
route_valid  out  1  decision available
route_ready  in  1  fabric accepts decision
route_src_port  out  PW  ingress port of decision
route_dst_port  out  PW  egress port
route_hit  out  1  1 = table match, 0 = default used
route_encap  out  1  captured encapsulated flag
miss_count  out  16  saturating count of misses
err_overflow  out  1  sticky: header pulse arrived on a port already pending

Behaviour:
- Reset (async assert, sync release):
  - Clear every table valid bit and every pending bit.
  - All outputs 0: hdr_ready, route_valid, route_src_port, route_dst_port, route_hit, route_encap, miss_count, err_overflow.
  - State IDLE; round-robin pointer last = NUM_PORTS-1, so port 0 has first priority.
  - Reset mid-LOOKUP or mid-RESULT abandons the decision. No hdr_ready is raised.
- Capture, every cycle and every state, per port i:
  - If hdr_valid[i]: latch ip_dest[i] and encap[i], set pending[i], clear hdr_ready[i].
  - If pending[i] is already set (and not being cleared that cycle): overwrite the captured data and set err_overflow.
- State IDLE:
  - If any pending, grant the first pending port searching from last+1 with wrap.
  - Load key = captured ip and cur = granted port; idx = 0; go to LOOKUP.
  - A pulse arriving in the same cycle is visible for grant next cycle.
- State LOOKUP (one entry per cycle):
  - Hit when entry[idx].en and (key & mask) == (ip & mask).
  - On hit: dst = entry port, hit = 1, go to RESULT.
  - If no hit and idx == TABLE_DEPTH-1: dst = DEFAULT_PORT, hit = 0, increment miss_count (saturating at 16'hFFFF), go to RESULT.
  - Otherwise idx++.
- Latency: grant at cycle 0, entry k compared in cycle k+1, route_valid high from cycle k+2. A full miss gives route_valid at cycle TABLE_DEPTH+1.
- State RESULT:
  - route_valid = 1; all route_* outputs are stable while route_valid is high.
  - On route_valid & route_ready: clear pending[cur], set hdr_ready[cur], last = cur, route_valid = 0 next cycle, go to IDLE.
  - Simultaneous hdr_valid[cur] in the handshake cycle: capture wins. pending stays 1, hdr_ready stays 0, no overflow flag.
- hdr_ready[i] is a level. It holds from route acceptance until that port's next hdr_valid, which satisfies the parser's WAIT-state polling.
- Config:
  - cfg_wr writes entry cfg_addr at the clock edge; writes are allowed in any state.
  - A comparison in the write cycle uses the old entry contents.
  - Entries already passed in the current lookup are not re-examined.
  - cfg_mask = 0 with cfg_en = 1 matches every key (default route).
- A mask of all ones requires an exact match. Overlapping entries resolve to the lowest index.

Test Plan:
- Entry0 {10.0.0.0, FF000000, port 2, en}; pulse port 1 with ip 0A010203 -> route_valid at cycle 2 after grant, src=1, dst=2, hit=1; after route_ready, hdr_ready[1]=1 until next hdr_valid[1].
- Empty table, pulse port 3 with any ip -> route_valid at cycle TABLE_DEPTH+1 (9), dst=DEFAULT_PORT, hit=0, miss_count=1.
- Pulses on ports 0, 1, 2, 3 in the same cycle, route_ready tied high -> decisions in order 0,1,2,3; then re-pulse ports 3 and 0 -> order 0, then 3.
- Entry5 {C0A80001, FFFFFFFF, port 1}, entry6 {0, 0, port 3}; key C0A80001 -> dst 1; key C0A80002 -> dst 3 at cycle 8.
- Hold route_ready low for 10 cycles in RESULT -> outputs stable; pulse the same port twice before grant -> err_overflow=1 and the second ip is used.
- Assert axis_resetn low mid-LOOKUP, then release -> all outputs 0, table empty; a subsequent lookup misses.
